// File: rtl/encrypt_pipe_core_if.sv
// Byte-stream bus for the encrypt pipe: input byte with valid strobe,
// encrypted byte with valid strobe. No backpressure in either direction.
interface encrypt_pipe_core_if;
  logic       en;
  logic [7:0] din;
  logic       v;
  logic [7:0] dout;

  modport master (output en, din, input v, dout);
  modport slave  (input en, din, output v, dout);
endinterface

// File: rtl/encrypt_pipe_core.sv
// Three-stage encrypt pipe: classify, Caesar-shift alphabetic bytes, XOR with a
// key that optionally rotates k1->k2->k3 every rot_freq valid bytes.
module encrypt_pipe_core (
  input  logic                       clk,
  input  logic                       rst,
  encrypt_pipe_core_if.slave         bus,
  input  logic [7:0]                 k1,
  input  logic [7:0]                 k2,
  input  logic [7:0]                 k3,
  input  logic [2:0]                 rot_freq,
  input  logic                       shift_en,
  input  logic [3:0]                 shift_amt,
  input  logic                       mode
);

  typedef enum logic [1:0] {KEY1, KEY2, KEY3} key_state_t;

  logic       s1_valid, s1_alpha, s1_lower;
  logic [7:0] s1_byte;
  logic [4:0] s1_offset;
  logic       s2_valid;
  logic [7:0] s2_byte;
  logic       s3_valid;
  logic [7:0] s3_byte;

  logic       in_upper, in_lower;
  logic [4:0] in_offset;
  logic [5:0] s2_sum, s2_wrap;
  logic [7:0] s2_shifted;

  key_state_t key_state, key_next;
  logic [2:0] cnt, cnt_next, cnt_inc;
  logic       key_rotating;
  logic [7:0] key_sel;

  // 'A' and 'a' both have low five bits 5'b00001, so the offset needs no base subtraction.
  always_comb begin
    in_upper  = (bus.din >= 8'h41) && (bus.din <= 8'h5A);
    in_lower  = (bus.din >= 8'h61) && (bus.din <= 8'h7A);
    in_offset = bus.din[4:0] - 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_alpha  <= 1'b0;
      s1_lower  <= 1'b0;
      s1_byte   <= 8'h00;
      s1_offset <= 5'd0;
    end else begin
      s1_valid  <= bus.en;
      s1_alpha  <= in_upper || in_lower;
      s1_lower  <= in_lower;
      s1_byte   <= bus.din;
      s1_offset <= in_offset;
    end
  end

  // Six-bit sum: offset 25 plus shift 15 reaches 40, which would alias in five bits.
  always_comb begin
    s2_sum     = {1'b0, s1_offset} + {2'b00, shift_amt};
    s2_wrap    = (s2_sum >= 6'd26) ? (s2_sum - 6'd26) : s2_sum;
    s2_shifted = (s1_lower ? 8'h61 : 8'h41) + {2'b00, s2_wrap};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_byte  <= 8'h00;
      s3_valid <= 1'b0;
      s3_byte  <= 8'h00;
    end else begin
      s2_valid <= s1_valid;
      s2_byte  <= (shift_en && s1_alpha) ? s2_shifted : s1_byte;
      s3_valid <= s2_valid;
      s3_byte  <= s2_byte;
    end
  end

  always_comb begin
    key_rotating = mode && (rot_freq != 3'd0);
    cnt_inc      = cnt + 3'd1;
    key_sel      = k1;
    if (key_rotating) begin
      case (key_state)
        KEY2:    key_sel = k2;
        KEY3:    key_sel = k3;
        default: key_sel = k1;
      endcase
    end
  end

  // Only valid bytes advance the key; bubbles leave count and key untouched.
  always_comb begin
    key_next = key_state;
    cnt_next = cnt;
    if (s3_valid && key_rotating) begin
      if (cnt_inc == rot_freq) begin
        cnt_next = 3'd0;
        case (key_state)
          KEY1:    key_next = KEY2;
          KEY2:    key_next = KEY3;
          default: key_next = KEY1;
        endcase
      end else begin
        cnt_next = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state <= KEY1;
      cnt       <= 3'd0;
    end else begin
      key_state <= key_next;
      cnt       <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.v    <= 1'b0;
      bus.dout <= 8'h00;
    end else begin
      bus.v <= s3_valid;
      if (s3_valid) begin
        bus.dout <= s3_byte ^ key_sel;
      end
    end
  end

endmodule
